// File: rtl/ram_word_packer.sv
// -----------------------------------------------------------------------------
// ram_word_packer
//
// Packs the byte stream coming out of the ram stage into BYTES-wide words,
// little-endian (the first byte of a word lands in bits [7:0]). Finished words
// go into a small FIFO that drives a valid/ready output. A running modulo-256
// checksum of every accepted byte is kept for self-check.
//
// Ports
//   clock       in   1          rising-edge clock
//   resetn      in   1          synchronous reset, active-low
//   ram_out     in   8          byte from the ram stage
//   byte_valid  in   1          ram_out carries a new byte this cycle
//   word_ready  in   1          downstream takes word_data this cycle
//   word_data   out  8*BYTES    FIFO head word, byte0 in [7:0]
//   word_valid  out  1          FIFO not empty
//   byte_count  out  3          bytes held in the partial word (assembler state)
//   checksum    out  8          sum mod 256 of all accepted bytes since reset
//   overflow    out  1          sticky: a completed word was dropped (FIFO full)
//
// Handshake: a word transfers on a rising edge where word_valid and word_ready
// are both 1. word_valid never depends on word_ready, and word_data/word_valid
// hold steady while word_valid=1 and word_ready=0. word_ready is ignored while
// the FIFO is empty. There is no backpressure on the byte input: a completed
// word that finds the FIFO full (and not popping) is dropped and overflow set.
// -----------------------------------------------------------------------------
module ram_word_packer #(
    parameter int BYTES = 4,
    parameter int DEPTH = 2
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [7:0]         ram_out,
    input  logic               byte_valid,
    input  logic               word_ready,
    output logic [8*BYTES-1:0] word_data,
    output logic               word_valid,
    output logic [2:0]         byte_count,
    output logic [7:0]         checksum,
    output logic               overflow
);

    localparam int W  = 8 * BYTES;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [2:0]    LAST_LANE = 3'(BYTES - 1);

    // ---------------------------------------------------------------- state
    logic [2:0]    byte_count_q, byte_count_d;
    logic [W-1:0]  lanes_q,      lanes_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q,     wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,     rd_ptr_d;
    logic [7:0]    checksum_q,   checksum_d;
    logic          overflow_q,   overflow_d;

    // ---------------------------------------------------------------- datapath
    logic [W-1:0]  word_in;
    logic          last_byte;
    logic          push_req;
    logic          pop;
    logic          do_push;
    logic          fifo_full;
    logic          fifo_empty;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    // Extra pointer bit separates "wrapped once" (full) from "caught up" (empty).
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign last_byte = (byte_count_q == LAST_LANE);
    assign push_req  = byte_valid && last_byte;
    assign pop       = !fifo_empty && word_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign do_push   = push_req && (!fifo_full || pop);

    // The completing word is built from the held lanes plus the byte arriving
    // now, so it can be written into the FIFO on the same edge.
    always_comb begin
        word_in = lanes_q;
        for (int i = 0; i < BYTES; i++) begin
            if (byte_count_q == 3'(i)) begin
                word_in[8*i +: 8] = ram_out;
            end
        end
    end

    // ---------------------------------------------------------------- assembler FSM
    // The state is simply the number of lanes already filled (S0..S(BYTES-1)).
    always_comb begin
        byte_count_d = byte_count_q;
        lanes_d      = lanes_q;
        if (byte_valid) begin
            if (last_byte) begin
                byte_count_d = 3'd0;
                lanes_d      = '0;
            end else begin
                byte_count_d = byte_count_q + 3'd1;
                lanes_d      = word_in;
            end
        end
    end

    // ---------------------------------------------------------------- FIFO
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = word_in;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // ---------------------------------------------------------------- status
    always_comb begin
        checksum_d = checksum_q;
        overflow_d = overflow_q;
        // Every accepted byte counts, even one that completes a dropped word.
        if (byte_valid) begin
            checksum_d = checksum_q + ram_out;
        end
        if (push_req && !do_push) begin
            overflow_d = 1'b1;
        end
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clock) begin
        if (!resetn) begin
            byte_count_q <= 3'd0;
            lanes_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            checksum_q   <= 8'd0;
            overflow_q   <= 1'b0;
            // Storage is cleared so word_data reads 0 straight after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            byte_count_q <= byte_count_d;
            lanes_q      <= lanes_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            checksum_q   <= checksum_d;
            overflow_q   <= overflow_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    // Head is read straight from storage; contents are stale while empty.
    assign word_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign word_valid = !fifo_empty;
    assign byte_count = byte_count_q;
    assign checksum   = checksum_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ram_word_packer.sv
module tb_ram_word_packer;

  localparam int BYTES = 4;
  localparam int DEPTH = 2;
  localparam int W     = 8 * BYTES;

  // ---------------------------------------------------------------- clock/reset
  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic [7:0]   ram_out = 8'd0;
  logic         byte_valid = 1'b0;
  logic         word_ready = 1'b0;
  logic [W-1:0] word_data;
  logic         word_valid;
  logic [2:0]   byte_count;
  logic [7:0]   checksum;
  logic         overflow;

  always #5 clock = ~clock;

  ram_word_packer #(.BYTES(BYTES), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .ram_out    (ram_out),
    .byte_valid (byte_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_valid (word_valid),
    .byte_count (byte_count),
    .checksum   (checksum),
    .overflow   (overflow)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // Bytes collected so far, completed words in order, running sum, sticky drop.
  logic [W-1:0] exp_q[$];
  logic [7:0]   part_q[$];
  int           m_sum = 0;
  bit           m_ovf = 1'b0;
  bit           model_live = 1'b0;

  always @(posedge clock) begin
    if (!resetn) begin
      exp_q.delete();
      part_q.delete();
      m_sum      = 0;
      m_ovf      = 1'b0;
      model_live = 1'b1;
    end else if (model_live) begin
      bit popping;
      popping = (exp_q.size() > 0) && word_ready;
      if (popping) void'(exp_q.pop_front());
      if (byte_valid) begin
        part_q.push_back(ram_out);
        m_sum = (m_sum + int'(ram_out)) % 256;
        if (part_q.size() == BYTES) begin
          logic [W-1:0] w;
          for (int i = 0; i < BYTES; i++) w[8*i +: 8] = part_q[i];
          part_q.delete();
          if (exp_q.size() < DEPTH) exp_q.push_back(w);
          else m_ovf = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- scoreboard compare
  always @(posedge clock) begin
    #1;
    if (model_live) begin
      check("word_valid", 64'(word_valid), 64'(exp_q.size() > 0));
      check("byte_count", 64'(byte_count), 64'(part_q.size()));
      check("checksum",   64'(checksum),   64'(m_sum));
      check("overflow",   64'(overflow),   64'(m_ovf));
      if (exp_q.size() > 0) check("word_data", 64'(word_data), 64'(exp_q[0]));
    end
  end

  // ---------------------------------------------------------------- driver
  // One clock: inputs applied at the falling edge, returns 1 time unit after
  // the rising edge that consumed them.
  task automatic cyc(input logic rst_n, input logic bv, input logic [7:0] b, input logic rdy);
    @(negedge clock);
    resetn     = rst_n;
    byte_valid = bv;
    ram_out    = b;
    word_ready = rdy;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b1, 8'h5A, 1'b0);
  endtask

  // ---------------------------------------------------------------- directed tests
  initial begin
    // 1: reset held two cycles with bytes streaming
    cyc(1'b0, 1'b1, 8'h55, 1'b1);
    cyc(1'b0, 1'b1, 8'h66, 1'b1);
    check("rst word_valid", 64'(word_valid), 64'd0);
    check("rst word_data",  64'(word_data),  64'd0);
    check("rst byte_count", 64'(byte_count), 64'd0);
    check("rst checksum",   64'(checksum),   64'd0);
    check("rst overflow",   64'(overflow),   64'd0);

    // 2: pack one word
    cyc(1'b1, 1'b1, 8'h11, 1'b0);
    check("pack count1", 64'(byte_count), 64'd1);
    cyc(1'b1, 1'b1, 8'h22, 1'b0);
    cyc(1'b1, 1'b1, 8'h33, 1'b0);
    check("pack no early valid", 64'(word_valid), 64'd0);
    cyc(1'b1, 1'b1, 8'h44, 1'b0);
    check("pack valid",    64'(word_valid), 64'd1);
    check("pack data",     64'(word_data),  64'h44332211);
    check("pack checksum", 64'(checksum),   64'hAA);
    check("pack count0",   64'(byte_count), 64'd0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    check("pack hold data", 64'(word_data), 64'h44332211);
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    check("pack popped", 64'(word_valid), 64'd0);

    // 3: overflow, then drain in order
    do_reset();
    for (int i = 1; i <= 12; i++) cyc(1'b1, 1'b1, 8'(i), 1'b0);
    check("ovf flag",     64'(overflow),  64'd1);
    check("ovf checksum", 64'(checksum),  64'h4E);
    check("ovf head",     64'(word_data), 64'h04030201);
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    check("ovf second",   64'(word_data), 64'h08070605);
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    check("ovf drained",  64'(word_valid), 64'd0);
    check("ovf sticky",   64'(overflow),   64'd1);

    // 4: full FIFO with pop on the edge that completes the third word
    do_reset();
    for (int i = 1; i <= 11; i++) cyc(1'b1, 1'b1, 8'(i), 1'b0);
    cyc(1'b1, 1'b1, 8'h0C, 1'b1);
    check("full+pop overflow", 64'(overflow),  64'd0);
    check("full+pop head",     64'(word_data), 64'h08070605);
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    check("full+pop next",     64'(word_data), 64'h0C0B0A09);
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    check("full+pop empty",    64'(word_valid), 64'd0);

    // 5: gapped bytes and checksum wrap
    do_reset();
    for (int i = 0; i < 7; i++) cyc(1'b1, (i % 2 == 0), 8'hFF, 1'b0);
    check("gap valid",    64'(word_valid), 64'd1);
    check("gap data",     64'(word_data),  64'hFFFFFFFF);
    check("gap checksum", 64'(checksum),   64'hFC);

    // 6: reset mid-word
    do_reset();
    cyc(1'b1, 1'b1, 8'hAA, 1'b0);
    cyc(1'b1, 1'b1, 8'hBB, 1'b0);
    check("mid count2", 64'(byte_count), 64'd2);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check("mid rst count",    64'(byte_count), 64'd0);
    check("mid rst checksum", 64'(checksum),   64'd0);
    check("mid rst valid",    64'(word_valid), 64'd0);
    for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b1, 8'(i), 1'b0);
    check("mid fresh word",  64'(word_data), 64'h04030201);
    check("mid fresh sum",   64'(checksum),  64'h0A);

    // Mixed pattern: irregular byte gaps and ready, covered by the model only.
    do_reset();
    for (int i = 0; i < 60; i++)
      cyc(1'b1, (i % 3 != 0), 8'(i * 7 + 3), (i % 5 == 0) || (i % 7 == 0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
